// File: rtl/reg4_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg4_arb_pkg
// Shared definitions for the two-port write arbiter of the 4-bit datapath
// register: one-hot FSM state encoding, number of requesters and the reset
// value of the round-robin history bit.
// -----------------------------------------------------------------------------
package reg4_arb_pkg;

  // Number of requesters served by the arbiter.
  localparam int REQ_N = 2;

  // last_grant starts at 1 so that requester 0 wins the first tie after reset.
  localparam logic LAST_GRANT_RST = 1'b1;

  // Bit positions inside the one-hot state vector.
  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_WRITE_BIT = 1;
  localparam int ST_ACK_BIT   = 2;

  // One-hot FSM encoding, held directly in flops.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_WRITE = 3'b010,
    ST_ACK   = 3'b100
  } state_t;

endpackage

// File: rtl/reg4_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg4_write_arbiter_if
// Bundles the requester handshakes, the register write/read-back path and the
// status outputs of reg4_write_arbiter.
//
//   req0/din0/ack0 : requester 0 request, write data, one-cycle completion
//   req1/din1/ack1 : requester 1 request, write data, one-cycle completion
//   Ce/Dreg        : clock enable and data towards register_4bit
//   Qreg           : register_4bit output, used for read-back checking
//   busy           : arbiter not idle
//   last_grant     : index of the most recently granted requester
//   err            : sticky read-back mismatch flag
//
// Modports:
//   slave  : the arbiter side
//   master : the surrounding logic (requesters and register)
// -----------------------------------------------------------------------------
interface reg4_write_arbiter_if #(
  parameter int WIDTH = 4
);

  logic             req0;
  logic [WIDTH-1:0] din0;
  logic             ack0;
  logic             req1;
  logic [WIDTH-1:0] din1;
  logic             ack1;
  logic             Ce;
  logic [WIDTH-1:0] Dreg;
  logic [WIDTH-1:0] Qreg;
  logic             busy;
  logic             last_grant;
  logic             err;

  modport slave (
    input  req0, din0, req1, din1, Qreg,
    output ack0, ack1, Ce, Dreg, busy, last_grant, err
  );

  modport master (
    output req0, din0, req1, din1, Qreg,
    input  ack0, ack1, Ce, Dreg, busy, last_grant, err
  );

endinterface

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//
//   req0, req1  : candidate requests (already masked by the caller if needed)
//   last_grant  : requester granted most recently
//   valid       : at least one request present
//   pick        : chosen requester index; on a tie, the one != last_grant
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic pick
);

  always_comb begin
    valid = req0 | req1;
    pick  = 1'b0;
    if (req0 && req1) begin
      // Tie: hand the slot to whoever did not go last.
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end
  end

endmodule

// File: rtl/reg4_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg4_write_arbiter
// Two-port round-robin write arbiter and sequencer for the shared 4-bit
// clock-enabled register. A granted request is written with a single-cycle
// Ce pulse, read back on the following cycle, then acknowledged. A read-back
// mismatch raises a sticky error flag.
//
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset (shared with register_4bit)
//   bus  : reg4_write_arbiter_if.slave - requester handshakes, register
//          Ce/Dreg/Qreg and the busy/last_grant/err status outputs
//
// Flow: IDLE -> WRITE (Ce=1) -> ACK (ack, read-back) -> IDLE, or ACK -> WRITE
// directly when the other requester is waiting.
// -----------------------------------------------------------------------------
module reg4_write_arbiter
  import reg4_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  reg4_write_arbiter_if.slave  bus
);

  state_t             state_q,      state_d;
  logic [WIDTH-1:0]   wdata_q,      wdata_d;
  logic [WIDTH-1:0]   dreg_q,       dreg_d;
  logic               ce_q,         ce_d;
  logic [REQ_N-1:0]   ack_q,        ack_d;
  logic               grant_q,      grant_d;
  logic               last_grant_q, last_grant_d;
  logic               err_q,        err_d;

  logic               pick_req0;
  logic               pick_req1;
  logic               pick_valid;
  logic               pick;

  // In ACK the requester being acknowledged is hidden from the picker so it
  // can never be re-granted back-to-back; only the other side may chain in.
  always_comb begin
    pick_req0 = bus.req0;
    pick_req1 = bus.req1;
    if (state_q == ST_ACK) begin
      if (grant_q) begin
        pick_req1 = 1'b0;
      end else begin
        pick_req0 = 1'b0;
      end
    end
  end

  rr_pick2 u_pick (
    .req0       (pick_req0),
    .req1       (pick_req1),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .pick       (pick)
  );

  // Next-state and registered-output logic. Ce and ack are computed one
  // cycle ahead so that they come straight out of flops in WRITE and ACK.
  always_comb begin
    state_d      = state_q;
    wdata_d      = wdata_q;
    dreg_d       = dreg_q;
    ce_d         = 1'b0;
    ack_d        = '0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_WRITE;
          grant_d      = pick;
          last_grant_d = pick;
          wdata_d      = pick ? bus.din1 : bus.din0;
          dreg_d       = wdata_d;
          ce_d         = 1'b1;
        end
      end

      ST_WRITE: begin
        // Register captures Dreg at the end of this cycle; acknowledge next.
        state_d = ST_ACK;
        if (grant_q) begin
          ack_d[1] = 1'b1;
        end else begin
          ack_d[0] = 1'b1;
        end
      end

      ST_ACK: begin
        // Qreg now reflects the write that just completed.
        if (bus.Qreg != wdata_q) begin
          err_d = 1'b1;
        end
        if (pick_valid) begin
          state_d      = ST_WRITE;
          grant_d      = pick;
          last_grant_d = pick;
          wdata_d      = pick ? bus.din1 : bus.din0;
          dreg_d       = wdata_d;
          ce_d         = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      wdata_q      <= '0;
      dreg_q       <= '0;
      ce_q         <= 1'b0;
      ack_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= LAST_GRANT_RST;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdata_q      <= wdata_d;
      dreg_q       <= dreg_d;
      ce_q         <= ce_d;
      ack_q        <= ack_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign bus.Ce         = ce_q;
  assign bus.Dreg       = dreg_q;
  assign bus.ack0       = ack_q[0];
  assign bus.ack1       = ack_q[1];
  assign bus.last_grant = last_grant_q;
  assign bus.err        = err_q;
  assign bus.busy       = state_q[ST_WRITE_BIT] | state_q[ST_ACK_BIT];

endmodule

// File: tb/tb_reg4_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg4_write_arbiter
// Self-checking bench for reg4_write_arbiter. Models register_4bit, drives the
// two requesters and keeps a queue of expected (requester, data) writes that
// is consumed whenever the arbiter acknowledges.
// -----------------------------------------------------------------------------
module tb_reg4_write_arbiter;

  localparam int WIDTH = 4;
  // {Ce, Dreg, ack0, ack1, busy, last_grant, err} after reset
  localparam logic [9:0] RST_VEC = 10'b0_0000_0_0_0_1_0;

  logic CLK = 1'b0;
  logic RST;

  reg4_write_arbiter_if #(.WIDTH(WIDTH)) bus ();

  reg4_write_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // register_4bit model, with an override to corrupt read-back
  logic [WIDTH-1:0] reg_q;
  logic             force_zero;

  always @(posedge CLK or posedge RST) begin
    if (RST)         reg_q <= '0;
    else if (bus.Ce) reg_q <= bus.Dreg;
  end

  assign bus.Qreg = force_zero ? '0 : reg_q;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_en = 1'b0;

  // Every acknowledge must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_en && !RST && (bus.ack0 || bus.ack1)) begin
      total++;
      if (bus.ack0 && bus.ack1) begin
        bad++;
        $display("FAIL sb_ack_both ack0=%0b ack1=%0b required one-hot", bus.ack0, bus.ack1);
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_ack ack0=%0b ack1=%0b required no ack", bus.ack0, bus.ack1);
      end else begin
        e = sb.pop_front();
        if (bus.ack1 !== e.id || reg_q !== e.data) begin
          bad++;
          $display("FAIL sb_write got id=%0d reg=%h required id=%0d reg=%h",
                   bus.ack1, reg_q, e.id, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    #2;
    RST = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [9:0] v;
    RST = 1'b0;
    #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    v = {bus.Ce, bus.Dreg, bus.ack0, bus.ack1, bus.busy, bus.last_grant, bus.err};
    total++;
    if (v !== RST_VEC) begin
      bad++;
      $display("FAIL reset_initial got=%b required=%b", v, RST_VEC);
    end
    tick();
    RST = 1'b0;
    // random traffic, then reset asynchronously in the middle of a cycle
    sb_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.din0 = 4'($urandom);
      bus.din1 = 4'($urandom);
      tick();
    end
    #2;
    RST = 1'b1;
    #1;
    v = {bus.Ce, bus.Dreg, bus.ack0, bus.ack1, bus.busy, bus.last_grant, bus.err};
    total++;
    if (v !== RST_VEC) begin
      bad++;
      $display("FAIL reset_mid got=%b required=%b", v, RST_VEC);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_single_write();
    tick();
    bus.din0 = 4'hA;
    bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, data: 4'hA});
    @(negedge CLK);
    total++;
    if ({bus.busy, bus.Ce} !== 2'b00) begin
      bad++;
      $display("FAIL single_idle got busy,Ce=%b required 00", {bus.busy, bus.Ce});
    end
    @(negedge CLK);
    total++;
    if ({bus.Ce, bus.Dreg, bus.busy, bus.ack0} !== {1'b1, 4'hA, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_write got Ce=%b Dreg=%h busy=%b ack0=%b required 1 a 1 0",
               bus.Ce, bus.Dreg, bus.busy, bus.ack0);
    end
    @(negedge CLK);
    total++;
    if ({bus.ack0, bus.ack1, bus.Ce, bus.busy, bus.Qreg} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'hA}) begin
      bad++;
      $display("FAIL single_ack got ack0=%b ack1=%b Ce=%b busy=%b Qreg=%h required 1 0 0 1 a",
               bus.ack0, bus.ack1, bus.Ce, bus.busy, bus.Qreg);
    end
    tick();
    bus.req0 = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.busy, bus.ack0, bus.err} !== 3'b000) begin
      bad++;
      $display("FAIL single_done got busy,ack0,err=%b required 000", {bus.busy, bus.ack0, bus.err});
    end
  endtask

  task automatic test_tie_after_reset();
    apply_reset();
    bus.din0 = 4'h3;
    bus.din1 = 4'hC;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    sb.push_back('{id: 1'b0, data: 4'h3});
    sb.push_back('{id: 1'b1, data: 4'hC});
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if ({bus.Ce, bus.Dreg} !== {1'b1, 4'h3}) begin
      bad++;
      $display("FAIL tie_write0 got Ce=%b Dreg=%h required 1 3", bus.Ce, bus.Dreg);
    end
    @(negedge CLK);
    total++;
    if ({bus.ack0, bus.Qreg} !== {1'b1, 4'h3}) begin
      bad++;
      $display("FAIL tie_ack0 got ack0=%b Qreg=%h required 1 3", bus.ack0, bus.Qreg);
    end
    tick();
    bus.req0 = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.Ce, bus.Dreg, bus.last_grant, bus.ack0} !== {1'b1, 4'hC, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL tie_write1 got Ce=%b Dreg=%h last_grant=%b ack0=%b required 1 c 1 0",
               bus.Ce, bus.Dreg, bus.last_grant, bus.ack0);
    end
    @(negedge CLK);
    total++;
    if ({bus.ack1, bus.ack0, bus.Qreg} !== {1'b1, 1'b0, 4'hC}) begin
      bad++;
      $display("FAIL tie_ack1 got ack1=%b ack0=%b Qreg=%h required 1 0 c",
               bus.ack1, bus.ack0, bus.Qreg);
    end
    tick();
    bus.req1 = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.Qreg, bus.last_grant, bus.busy} !== {4'hC, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL tie_final got Qreg=%h last_grant=%b busy=%b required c 1 0",
               bus.Qreg, bus.last_grant, bus.busy);
    end
  endtask

  task automatic test_readback_error();
    int n;
    tick();
    bus.din0 = 4'h5;
    bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, data: 4'h5});
    @(negedge CLK);
    @(negedge CLK);
    tick();
    force_zero = 1'b1;
    @(negedge CLK);
    total++;
    if ({bus.ack0, bus.Qreg} !== {1'b1, 4'h0}) begin
      bad++;
      $display("FAIL err_ack got ack0=%b Qreg=%h required 1 0", bus.ack0, bus.Qreg);
    end
    tick();
    force_zero = 1'b0;
    bus.req0 = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.err !== 1'b1) begin
      bad++;
      $display("FAIL err_set got err=%b required 1", bus.err);
    end
    // a good write afterwards must leave err set
    tick();
    bus.din1 = 4'h9;
    bus.req1 = 1'b1;
    sb.push_back('{id: 1'b1, data: 4'h9});
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.ack1 && n < 10);
    total++;
    if (bus.ack1 !== 1'b1) begin
      bad++;
      $display("FAIL err_good_write_timeout got ack1=%b required 1 within 10 cycles", bus.ack1);
    end
    tick();
    bus.req1 = 1'b0;
    @(negedge CLK);
    total++;
    if ({bus.err, bus.Qreg} !== {1'b1, 4'h9}) begin
      bad++;
      $display("FAIL err_sticky got err=%b Qreg=%h required 1 9", bus.err, bus.Qreg);
    end
  endtask

  task automatic test_reset_during_ack();
    logic [9:0] v;
    tick();
    bus.din0 = 4'h6;
    bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, data: 4'h6});
    @(negedge CLK);
    @(negedge CLK);
    tick();
    #2;
    RST = 1'b1;
    #1;
    v = {bus.Ce, bus.Dreg, bus.ack0, bus.ack1, bus.busy, bus.last_grant, bus.err};
    total++;
    if (v !== RST_VEC) begin
      bad++;
      $display("FAIL reset_in_ack got=%b required=%b", v, RST_VEC);
    end
    bus.req0 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset_during_write();
    int n;
    bit seen_ack;
    tick();
    bus.din1 = 4'h7;
    bus.req1 = 1'b1;
    sb.push_back('{id: 1'b1, data: 4'h7});
    @(negedge CLK);
    @(negedge CLK);
    total++;
    if ({bus.Ce, bus.Dreg} !== {1'b1, 4'h7}) begin
      bad++;
      $display("FAIL rstw_write got Ce=%b Dreg=%h required 1 7", bus.Ce, bus.Dreg);
    end
    #1;
    RST = 1'b1;
    #1;
    total++;
    if ({bus.Ce, bus.ack1, bus.busy, bus.Qreg} !== {1'b0, 1'b0, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL rstw_drop got Ce=%b ack1=%b busy=%b Qreg=%h required 0 0 0 0",
               bus.Ce, bus.ack1, bus.busy, bus.Qreg);
    end
    seen_ack = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (bus.ack1) seen_ack = 1'b1;
    end
    total++;
    if (seen_ack !== 1'b0) begin
      bad++;
      $display("FAIL rstw_no_ack got ack1 seen=%b required 0", seen_ack);
    end
    @(posedge CLK);
    #1;
    sb.delete();
    RST = 1'b0;
    // req1 still high: that is the re-request
    sb.push_back('{id: 1'b1, data: 4'h7});
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!bus.ack1 && n < 10);
    total++;
    if ({bus.ack1, bus.Qreg} !== {1'b1, 4'h7}) begin
      bad++;
      $display("FAIL rstw_rerequest got ack1=%b Qreg=%h required 1 7", bus.ack1, bus.Qreg);
    end
    tick();
    bus.req1 = 1'b0;
  endtask

  task automatic test_fairness();
    bit a0, a1, stop, exp_id, order_ok, drained;
    int nacks;
    apply_reset();
    a0 = 1'b0;
    a1 = 1'b0;
    stop = 1'b0;
    exp_id = 1'b0;
    order_ok = 1'b1;
    drained = 1'b0;
    nacks = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      // requesters drop for one cycle after their ack, then come straight back
      if (a0) begin
        bus.req0 = 1'b0;
      end else if (!bus.req0 && !stop) begin
        bus.din0 = 4'($urandom);
        bus.req0 = 1'b1;
        sb.push_back('{id: 1'b0, data: bus.din0});
      end
      if (a1) begin
        bus.req1 = 1'b0;
      end else if (!bus.req1 && !stop) begin
        bus.din1 = 4'($urandom);
        bus.req1 = 1'b1;
        sb.push_back('{id: 1'b1, data: bus.din1});
      end
      @(negedge CLK);
      a0 = bus.ack0;
      a1 = bus.ack1;
      if (a0 || a1) begin
        nacks++;
        if (a1 !== exp_id) begin
          order_ok = 1'b0;
          $display("FAIL fair_order got ack id=%0d required %0d at ack #%0d", a1, exp_id, nacks);
        end
        exp_id = ~exp_id;
      end
      if (cyc == 22) stop = 1'b1;
      if (stop && !bus.req0 && !bus.req1 && sb.size() == 0) begin
        drained = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (!order_ok) bad++;
    total++;
    if (!drained || nacks < 10) begin
      bad++;
      $display("FAIL fair_throughput got acks=%0d drained=%0b required >=10 and 1", nacks, drained);
    end
    tick();
  endtask

  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.din0 = '0;
    bus.din1 = '0;
    force_zero = 1'b0;
    test_reset();
    test_single_write();
    test_tie_after_reset();
    test_readback_error();
    test_reset_during_ack();
    test_reset_during_write();
    test_fairness();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg4_write_arbiter.md
# reg4_write_arbiter

Two-port write arbiter and sequencer for the shared 4-bit clock-enabled register (`register_4bit`) in the datapath. Two requesters each present a data nibble with a req/ack handshake. The block picks one requester using round-robin, drives the register's `Ce`/`Din` for exactly one cycle, and read-back-checks the register output before acknowledging. A sticky error flag reports any write that did not land.

## Interface
Parameters:
- `WIDTH`, default 4: data width. Must equal the register width.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: asynchronous, active-high reset. The same net also resets `register_4bit`.
- `req0`, in, 1: write request, requester 0.
- `din0`, in, WIDTH: write data, requester 0. Stable while `req0`=1 and until `ack0`.
- `ack0`, out, 1: one-cycle completion pulse to requester 0.
- `req1`, in, 1: write request, requester 1.
- `din1`, in, WIDTH: write data, requester 1.
- `ack1`, out, 1: one-cycle completion pulse to requester 1.
- `Ce`, out, 1: clock enable to the register.
- `Dreg`, out, WIDTH: data to the register `Din`.
- `Qreg`, in, WIDTH: register `Dout`, used for read-back.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `last_grant`, out, 1: index of the most recently granted requester.
- `err`, out, 1: sticky read-back mismatch flag.

## Operation
- **Reset values:** state=IDLE, `Ce`=0, `Dreg`=0, `ack0`=`ack1`=0, `busy`=0, `last_grant`=1, `err`=0, internal latched data=0, grant=0.
- **FSM states:** IDLE, WRITE, ACK. Encoding is one-hot and held in flops.
- **IDLE:**
  - If exactly one req is high, grant it.
  - If both are high, grant the requester ≠ `last_grant`. After reset, requester 0 therefore wins the first tie.
  - On grant: latch `dinN` into `wdata`, set `grant`=N and `last_grant`=N, then go to WRITE.
  - With no req, stay in IDLE.
- **WRITE:** `Ce`=1, `Dreg`=`wdata`. Go to ACK unconditionally.
- **ACK:**
  - `ack[grant]`=1 for this cycle only. `Ce`=0.
  - Compare `Qreg` with `wdata`. On mismatch set `err`=1. `err` clears only on `RST`.
  - If the other requester's req is high, grant it (latch its data, update `last_grant`) and go directly to WRITE. Otherwise go to IDLE.
  - The just-acked requester is never re-granted from ACK.
- **Requester protocol:**
  - A requester must deassert req in the cycle after its ack.
  - If req is still high in IDLE, it is treated as a new request. This is legal back-to-back behaviour.
- **Outputs:** `Ce`, `Dreg`, `ack0`, `ack1` and `err` are driven from flops. `busy` decodes from the one-hot state flops.
- **Width rule:** data passes through unmodified. No arithmetic is performed.

## Timing
- **Single-write latency:** req sampled high at edge k (state IDLE) → WRITE during cycle k..k+1 (`Ce`=1) → the register captures at edge k+1 → ACK during cycle k+1..k+2 (ack=1, `Qreg` valid).
- **Throughput:** one write per 3 cycles from IDLE. With alternating pending requests, one write per 2 cycles (ACK→WRITE).
- **Simultaneous requests:** the tie resolves via `last_grant` only. A single requester holding req continuously is never starved by the other, and never starves it.
- **Reset mid-operation (any state):** all outputs return to their reset values asynchronously. `Ce` drops immediately, no ack is issued, the pending transaction is discarded, and the requester must re-request.
- **Request withdrawn before grant:** ignored, no ack. A req dropped after grant is still completed and acked.

## Structure
- Shared package `reg4_arb_pkg` holds:
  - the state enum (IDLE/WRITE/ACK one-hot constants);
  - `REQ_N`=2;
  - the reset value of `last_grant`.
- Sub-module `rr_pick2` (combinational): inputs `req0`, `req1`, `last_grant`; outputs `valid` and `pick`. It is instantiated once, shared between the IDLE and ACK decisions; in ACK it is masked so it never returns `grant`.
- `register_4bit` is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** assert `RST` mid-simulation with random inputs → all outputs equal reset values within the same cycle. `last_grant`=1, `err`=0.
- **Single write:** `req0`=1, `din0`=0xA from IDLE → `Ce`=1 with `Dreg`=0xA one cycle later, `ack0` pulse the next cycle, `Qreg`=0xA, `err`=0, `busy` high for 2 cycles.
- **Tie after reset:** `req0`=`req1`=1, `din0`=0x3, `din1`=0xC →
  - register written 0x3 and `ack0` pulses;
  - ACK transitions straight to WRITE, register written 0xC, `ack1` two cycles after `ack0`;
  - final `Qreg`=0xC, `last_grant`=1.
- **Fairness:** both reqs held high for 20 cycles (each dropping for one cycle after its ack) → acks strictly alternate, 0,1,0,1…
- **Read-back error:** force `Qreg`=0x0 during ACK of a 0x5 write → `err`=1 and `ack0` still pulses. `err` stays 1 through later good writes until `RST`.
- **Reset during WRITE:** `req1` with 0x7, assert `RST` while `Ce`=1 → `Ce`=0 immediately, no `ack1`, `Qreg`=0. After release, re-request completes normally.
